// File: rtl/xnorpop_accum.sv
// Accumulates per-chunk XNOR popcounts into a signed +/-1 dot product and
// thresholds it into a binarized activation, with valid/ready on both sides.
module xnorpop_accum #(
  parameter int unsigned CNT_W = 9,
  parameter int unsigned ACC_W = 16,
  parameter int unsigned DOT_W = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       pop_sum,
  input  logic             pop_valid,
  input  logic             pop_last,
  output logic             pop_ready,
  input  logic [DOT_W-1:0] thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DOT_W-1:0] out_dot,
  output logic             out_act,
  output logic [CNT_W-1:0] out_nchunks,
  output logic             err_range,
  output logic             err_ovf
);

  localparam int unsigned POP_W = 8;
  localparam logic [POP_W-1:0] POP_MAX  = POP_W'(128);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << CNT_W) - 2);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic             over_c;
  logic             beat_c;
  logic             final_c;
  logic [POP_W-1:0] clamp_c;
  logic [CNT_W-1:0] n_c;
  logic [ACC_W-1:0] a_c;
  logic [DOT_W-1:0] dot_c;
  logic             act_c;

  // Only a stalled result blocks input; pop_valid never feeds back here.
  assign pop_ready = !(out_valid && !out_ready);

  // Beat qualification, clamp and final-beat result arithmetic.
  always_comb begin
    over_c  = 1'b0;
    beat_c  = 1'b0;
    final_c = 1'b0;
    clamp_c = pop_sum;
    n_c     = '0;
    a_c     = '0;
    dot_c   = '0;
    act_c   = 1'b0;

    over_c  = (pop_sum > POP_MAX);
    beat_c  = pop_valid && pop_ready;
    final_c = beat_c && (pop_last || (cnt == CNT_LAST));
    if (over_c) begin
      clamp_c = POP_MAX;
    end
    n_c   = cnt + CNT_W'(1);
    a_c   = acc + ACC_W'(clamp_c);
    // 2*a - 128*n with both terms zero-extended to the signed width.
    dot_c = DOT_W'({a_c, 1'b0}) - DOT_W'({n_c, 7'b0});
    act_c = ($signed(dot_c) >= $signed(thresh));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      out_dot     <= '0;
      out_act     <= 1'b0;
      out_nchunks <= '0;
      err_range   <= 1'b0;
      err_ovf     <= 1'b0;
    end else begin
      if (beat_c && over_c) begin
        err_range <= 1'b1;
      end
      if (final_c) begin
        // Finish happens in the same edge: load results, restart the vector.
        acc         <= '0;
        cnt         <= '0;
        out_valid   <= 1'b1;
        out_dot     <= dot_c;
        out_act     <= act_c;
        out_nchunks <= n_c;
        if (!pop_last) begin
          err_ovf <= 1'b1;
        end
      end else begin
        if (beat_c) begin
          acc <= a_c;
          cnt <= n_c;
        end
        if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_xnorpop_accum.sv
// Directed bench for xnorpop_accum: integer reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_xnorpop_accum;

  localparam int unsigned CNT_W = 9;
  localparam int unsigned ACC_W = 16;
  localparam int unsigned DOT_W = 18;
  localparam int MAX_CHUNKS = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       pop_sum = '0;
  logic             pop_valid = 1'b0;
  logic             pop_last = 1'b0;
  logic             pop_ready;
  logic [DOT_W-1:0] thresh = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [DOT_W-1:0] out_dot;
  logic             out_act;
  logic [CNT_W-1:0] out_nchunks;
  logic             err_range;
  logic             err_ovf;

  int tests = 0;
  int fails = 0;

  // Reference model state (plain integers).
  int m_sum = 0, m_cnt = 0, m_dot = 0, m_n = 0;
  bit m_valid = 0, m_act = 0, m_erange = 0, m_eovf = 0;

  xnorpop_accum #(.CNT_W(CNT_W), .ACC_W(ACC_W), .DOT_W(DOT_W)) dut (
    .clk(clk), .rst_n(rst_n), .pop_sum(pop_sum), .pop_valid(pop_valid),
    .pop_last(pop_last), .pop_ready(pop_ready), .thresh(thresh),
    .out_valid(out_valid), .out_ready(out_ready), .out_dot(out_dot),
    .out_act(out_act), .out_nchunks(out_nchunks), .err_range(err_range),
    .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sdot();
    return int'($signed(out_dot));
  endfunction

  // Model: a vector is the sum of clamped popcounts; result is 2*sum-128*n.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sum = 0; m_cnt = 0; m_dot = 0; m_n = 0;
      m_valid = 0; m_act = 0; m_erange = 0; m_eovf = 0;
    end else begin
      bit acc_ok, fin;
      int c;
      acc_ok = pop_valid && !(m_valid && !out_ready);
      fin = 0;
      if (acc_ok) begin
        c = (int'(pop_sum) > 128) ? 128 : int'(pop_sum);
        if (int'(pop_sum) > 128) m_erange = 1;
        m_sum += c;
        m_cnt += 1;
        fin = pop_last || (m_cnt == MAX_CHUNKS);
      end
      if (fin) begin
        m_dot = 2 * m_sum - 128 * m_cnt;
        m_act = (m_dot >= int'($signed(thresh)));
        m_n = m_cnt;
        m_valid = 1;
        if (!pop_last) m_eovf = 1;
        m_sum = 0;
        m_cnt = 0;
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
  end

  // Per-cycle comparison against the model, well away from the clock edge.
  always @(negedge clk) begin
    #3;
    chk("pop_ready", int'(pop_ready), int'(!(m_valid && !out_ready)));
    chk("out_valid", int'(out_valid), int'(m_valid));
    chk("out_dot", sdot(), m_dot);
    chk("out_act", int'(out_act), int'(m_act));
    chk("out_nchunks", int'(out_nchunks), m_n);
    chk("err_range", int'(err_range), int'(m_erange));
    chk("err_ovf", int'(err_ovf), int'(m_eovf));
  end

  // Present one beat (called at a negedge); returns at the negedge after it is taken.
  task automatic send(input int sum, input bit last, input int th);
    int k;
    pop_sum = 8'(sum);
    pop_last = last;
    thresh = DOT_W'(th);
    pop_valid = 1'b1;
    k = 0;
    while (!pop_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("send_timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic idle();
    pop_valid = 1'b0;
    pop_last = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_res(input string tag, input int dot, input int act, input int n);
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_dot"}, sdot(), dot);
    chk({tag, "_act"}, int'(out_act), act);
    chk({tag, "_n"}, int'(out_nchunks), n);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_dot", sdot(), 0);
    chk("rst_n", int'(out_nchunks), 0);
    chk("rst_err", int'(err_range) + int'(err_ovf), 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Single full-match chunk.
    send(128, 1, 0);
    expect_res("single", 128, 1, 1);
    idle();
    chk("single_clear", int'(out_valid), 0);

    // Three chunks: a=184, dot=-16 < 10.
    send(64, 0, 10);
    send(70, 0, 10);
    send(50, 1, 10);
    expect_res("three", -16, 0, 3);
    idle();

    // Backpressure: result stalls, next beat must wait.
    out_ready = 1'b0;
    send(10, 1, 0);
    expect_res("bp_first", -108, 0, 1);
    pop_sum = 8'd20; pop_last = 1'b1; pop_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready_low", int'(pop_ready), 0);
      chk("bp_dot_hold", sdot(), -108);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("bp_ready_high", int'(pop_ready), 1);
    @(negedge clk);
    expect_res("bp_second", -88, 0, 1);
    idle();

    // Back-to-back single-chunk vectors, one result per cycle.
    send(0, 1, 0);
    expect_res("b2b_0", -128, 0, 1);
    send(128, 1, 0);
    expect_res("b2b_1", 128, 1, 1);
    send(64, 1, 1);
    expect_res("b2b_2", 0, 0, 1);
    idle();

    // Out-of-range popcount clamps to 128 and latches the error.
    send(200, 1, 0);
    expect_res("range", 128, 1, 1);
    chk("range_err", int'(err_range), 1);
    idle();
    idle();
    chk("range_sticky", int'(err_range), 1);

    // Force-terminate at the maximum chunk count.
    for (int i = 0; i < MAX_CHUNKS; i++) send(0, 0, 0);
    expect_res("ovf", -65408, 0, 511);
    chk("ovf_err", int'(err_ovf), 1);
    send(5, 0, 0);
    chk("ovf_next_noresult", int'(out_valid), 0);
    send(3, 1, 0);
    expect_res("ovf_newvec", -240, 0, 2);
    idle();

    // Reset in mid-vector discards partial sums and clears sticky errors.
    send(100, 0, 0);
    send(100, 0, 0);
    pop_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_dot", sdot(), 0);
    chk("midrst_err", int'(err_range) + int'(err_ovf), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    send(64, 1, 0);
    expect_res("post_rst", 0, 1, 1);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
